multi_channel_com: RTL and testbench

Parametrised, multi-channel centre-of-mass engine for the 65 MHz video output pipeline. It accumulates mask-pixel coordinates for up to CHANNELS independent threshold masks per frame and snapshots the sums at each frame boundary. It then computes each channel's floor-average x/y with one shared sequential restoring divider, and presents all results together with a single-cycle valid strobe. It supersedes the single-channel centre-of-mass block and adds per-channel pixel counts, a minimum-population gate, and overrun detection.

---
 rtl/multi_channel_com.sv | 191 +++++++++++++++++++
 tb/tb_multi_channel_com.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_com.sv
// Multi-channel centre-of-mass engine: per-channel coordinate accumulation, frame snapshot,
// and one shared restoring divider producing floor-average x/y for every channel.
module multi_channel_com #(
   parameter int CHANNELS   = 2,
   parameter int H_WIDTH    = 11,
   parameter int V_WIDTH    = 10,
   parameter int HRES       = 1024,
   parameter int VRES       = 768,
   parameter int MIN_PIXELS = 16,
   localparam int CNT_W     = $clog2(HRES*VRES+1)
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic [H_WIDTH-1:0]          x_in,
   input  logic [V_WIDTH-1:0]          y_in,
   input  logic [CHANNELS-1:0]         valid_in,
   input  logic                        tabulate_in,
   output logic [CHANNELS*H_WIDTH-1:0] x_out,
   output logic [CHANNELS*V_WIDTH-1:0] y_out,
   output logic [CHANNELS*CNT_W-1:0]   count_out,
   output logic [CHANNELS-1:0]         found_out,
   output logic                        valid_out,
   output logic                        busy_out,
   output logic                        overrun_out
);
   localparam int SXW  = CNT_W + H_WIDTH;
   localparam int SYW  = CNT_W + V_WIDTH;
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int BC_W = $clog2(H_WIDTH + 1);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, NEXT, DONE} state_t;
   state_t state, state_n;

   logic [SXW-1:0]     acc_x [CHANNELS];
   logic [SXW-1:0]     snap_x [CHANNELS];
   logic [SYW-1:0]     acc_y [CHANNELS];
   logic [SYW-1:0]     snap_y [CHANNELS];
   logic [CNT_W-1:0]   acc_cnt [CHANNELS];
   logic [CNT_W-1:0]   snap_cnt [CHANNELS];
   logic [CNT_W-1:0]   stg_cnt [CHANNELS];
   logic [H_WIDTH-1:0] stg_x [CHANNELS];
   logic [V_WIDTH-1:0] stg_y [CHANNELS];
   logic [CHANNELS-1:0] stg_found;

   logic [CH_W-1:0]    ch;
   logic [BC_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]   rem, divisor, rem_nx;
   logic [CNT_W:0]     rem_sh;
   logic [H_WIDTH-1:0] div_lo, res_x, quo_nx;
   logic [H_WIDTH-2:0] quo;
   logic [V_WIDTH-1:0] res_y;
   logic               ch_found, in_range, skip, last_bit, ge;

   assign in_range = (32'(x_in) < HRES) && (32'(y_in) < VRES);
   assign skip     = (snap_cnt[ch] < MIN_CNT) || (snap_cnt[ch] == '0);
   assign last_bit = (bit_cnt == '0);
   assign busy_out = (state != IDLE);

   // One restoring step: bring in the next dividend bit, subtract when it fits.
   assign rem_sh = {rem, div_lo[H_WIDTH-1]};
   assign ge     = (rem_sh >= {1'b0, divisor});
   assign rem_nx = ge ? CNT_W'(rem_sh - {1'b0, divisor}) : rem_sh[CNT_W-1:0];
   assign quo_nx = {quo, ge};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = IDLE;
         LOAD:    state_n = skip ? NEXT : DIV_X;
         DIV_X:   if (last_bit) state_n = DIV_Y;
         DIV_Y:   if (last_bit) state_n = NEXT;
         NEXT:    state_n = (ch == LAST_CH) ? DONE : LOAD;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // A frame boundary always restarts the sweep, abandoning any work in flight.
      if (tabulate_in) state_n = LOAD;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int c = 0; c < CHANNELS; c++) begin
            acc_x[c]    <= '0;
            acc_y[c]    <= '0;
            acc_cnt[c]  <= '0;
            snap_x[c]   <= '0;
            snap_y[c]   <= '0;
            snap_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (tabulate_in) begin
               snap_x[c]   <= acc_x[c];
               snap_y[c]   <= acc_y[c];
               snap_cnt[c] <= acc_cnt[c];
               acc_x[c]    <= (valid_in[c] && in_range) ? SXW'(x_in) : '0;
               acc_y[c]    <= (valid_in[c] && in_range) ? SYW'(y_in) : '0;
               acc_cnt[c]  <= (valid_in[c] && in_range) ? CNT_W'(1) : '0;
            end else if (valid_in[c] && in_range) begin
               acc_x[c]    <= acc_x[c] + SXW'(x_in);
               acc_y[c]    <= acc_y[c] + SYW'(y_in);
               acc_cnt[c]  <= acc_cnt[c] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ch          <= '0;
         bit_cnt     <= '0;
         rem         <= '0;
         divisor     <= '0;
         div_lo      <= '0;
         quo         <= '0;
         res_x       <= '0;
         res_y       <= '0;
         ch_found    <= 1'b0;
         stg_found   <= '0;
         x_out       <= '0;
         y_out       <= '0;
         count_out   <= '0;
         found_out   <= '0;
         valid_out   <= 1'b0;
         overrun_out <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            stg_x[c]   <= '0;
            stg_y[c]   <= '0;
            stg_cnt[c] <= '0;
         end
      end else begin
         valid_out   <= 1'b0;
         overrun_out <= tabulate_in && (state != IDLE) && (state != DONE);
         case (state)
            LOAD: begin
               ch_found <= !skip;
               divisor  <= snap_cnt[ch];
               rem      <= snap_x[ch][SXW-1:H_WIDTH];
               div_lo   <= snap_x[ch][H_WIDTH-1:0];
               bit_cnt  <= BC_W'(H_WIDTH - 1);
            end
            DIV_X: begin
               quo <= quo_nx[H_WIDTH-2:0];
               if (last_bit) begin
                  res_x   <= quo_nx;
                  rem     <= snap_y[ch][SYW-1:V_WIDTH];
                  div_lo  <= H_WIDTH'(snap_y[ch][V_WIDTH-1:0]) << (H_WIDTH - V_WIDTH);
                  bit_cnt <= BC_W'(V_WIDTH - 1);
               end else begin
                  rem     <= rem_nx;
                  div_lo  <= div_lo << 1;
                  bit_cnt <= bit_cnt - BC_W'(1);
               end
            end
            DIV_Y: begin
               quo     <= quo_nx[H_WIDTH-2:0];
               rem     <= rem_nx;
               div_lo  <= div_lo << 1;
               bit_cnt <= bit_cnt - BC_W'(1);
               if (last_bit) res_y <= quo_nx[V_WIDTH-1:0];
            end
            NEXT: begin
               // Skipped channels carry the currently published centre forward.
               stg_cnt[ch]   <= snap_cnt[ch];
               stg_found[ch] <= ch_found;
               stg_x[ch]     <= ch_found ? res_x : x_out[ch*H_WIDTH +: H_WIDTH];
               stg_y[ch]     <= ch_found ? res_y : y_out[ch*V_WIDTH +: V_WIDTH];
               if (ch != LAST_CH) ch <= ch + CH_W'(1);
            end
            DONE: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  x_out[c*H_WIDTH +: H_WIDTH]   <= stg_x[c];
                  y_out[c*V_WIDTH +: V_WIDTH]   <= stg_y[c];
                  count_out[c*CNT_W +: CNT_W]   <= stg_cnt[c];
               end
               found_out <= stg_found;
               valid_out <= 1'b1;
            end
            default: ;
         endcase
         if (tabulate_in) ch <= '0;
      end
   end
endmodule

// File: tb/tb_multi_channel_com.sv
// Directed bench for multi_channel_com: two instances (default gate and MIN_PIXELS=1)
// share one stimulus stream; results, latencies and pulse counts are checked.
module tb_multi_channel_com;
   localparam int H  = 11;
   localparam int V  = 10;
   localparam int CW = 20;
   localparam int CH = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [H-1:0]  x_in;
   logic [V-1:0]  y_in;
   logic [CH-1:0] valid_in;
   logic          tabulate_in;

   logic [CH*H-1:0]  x0, x1;
   logic [CH*V-1:0]  y0, y1;
   logic [CH*CW-1:0] c0, c1;
   logic [CH-1:0]    f0, f1;
   logic valid0, valid1, busy0, busy1, ovr0, ovr1;

   int n_checks = 0, n_errors = 0;
   int cyc = 0, tab_cyc = 0, lat0 = -1, lat1 = -1;
   int v0_cnt = 0, v1_cnt = 0, ovr0_cnt = 0, ovr1_cnt = 0;
   logic [31:0] exp_q[$];

   multi_channel_com u_dut0 (
      .clk_in(clk), .rst_n_in(rst_n), .x_in(x_in), .y_in(y_in), .valid_in(valid_in),
      .tabulate_in(tabulate_in), .x_out(x0), .y_out(y0), .count_out(c0), .found_out(f0),
      .valid_out(valid0), .busy_out(busy0), .overrun_out(ovr0));

   multi_channel_com #(.MIN_PIXELS(1)) u_dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .x_in(x_in), .y_in(y_in), .valid_in(valid_in),
      .tabulate_in(tabulate_in), .x_out(x1), .y_out(y1), .count_out(c1), .found_out(f1),
      .valid_out(valid1), .busy_out(busy1), .overrun_out(ovr1));

   // clock / monitor
   always #8 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (tabulate_in) tab_cyc = cyc;
      if (valid0) begin v0_cnt++; lat0 = cyc - tab_cyc - 1; end
      if (valid1) begin v1_cnt++; lat1 = cyc - tab_cyc - 1; end
      if (ovr0) ovr0_cnt++;
      if (ovr1) ovr1_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input int x, input int y, input logic [CH-1:0] v, input logic t);
      x_in = H'(x); y_in = V'(y); valid_in = v; tabulate_in = t;
      @(posedge clk); #1;
      valid_in = '0; tabulate_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic feed_frame_a();
      for (int i = 0; i < 16; i++) drive(100 + i, 50, 2'b01, 1'b0);
      for (int i = 0; i < 16; i++) drive(300, 200 + i, 2'b10, 1'b0);
      drive(1024, 50, 2'b11, 1'b0);
      drive(100, 768, 2'b11, 1'b0);
   endtask

   task automatic tab_and_wait(input logic [CH-1:0] v, input int el0, input int el1);
      int b0, b1;
      b0 = v0_cnt; b1 = v1_cnt;
      drive(5, 6, v, 1'b1);
      idle(60);
      check("d0 valid pulses", 32'(v0_cnt - b0), 1);
      check("d1 valid pulses", 32'(v1_cnt - b1), 1);
      check("d0 latency", 32'(lat0), 32'(el0));
      check("d1 latency", 32'(lat1), 32'(el1));
   endtask

   // scoreboard
   task automatic exp_ch(input int x, input int y, input int n, input int f);
      exp_q.push_back(32'(x)); exp_q.push_back(32'(y));
      exp_q.push_back(32'(n)); exp_q.push_back(32'(f));
   endtask

   task automatic check_frame(input int sel);
      logic [31:0] ex, ey, en, ef;
      for (int c = 0; c < CH; c++) begin
         ex = exp_q.pop_front(); ey = exp_q.pop_front();
         en = exp_q.pop_front(); ef = exp_q.pop_front();
         if (sel == 0) begin
            check($sformatf("d0 x ch%0d", c), 32'(x0[c*H +: H]), ex);
            check($sformatf("d0 y ch%0d", c), 32'(y0[c*V +: V]), ey);
            check($sformatf("d0 count ch%0d", c), 32'(c0[c*CW +: CW]), en);
            check($sformatf("d0 found ch%0d", c), 32'(f0[c]), ef);
         end else begin
            check($sformatf("d1 x ch%0d", c), 32'(x1[c*H +: H]), ex);
            check($sformatf("d1 y ch%0d", c), 32'(y1[c*V +: V]), ey);
            check($sformatf("d1 count ch%0d", c), 32'(c1[c*CW +: CW]), en);
            check($sformatf("d1 found ch%0d", c), 32'(f1[c]), ef);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " x"}, 32'(x0), 0);
      check({tag, " y"}, 32'(y0), 0);
      check({tag, " count"}, 32'(c0[CW-1:0]) | 32'(c0[2*CW-1:CW]), 0);
      check({tag, " found"}, 32'(f0), 0);
      check({tag, " valid"}, 32'(valid0), 0);
      check({tag, " busy"}, 32'(busy0), 0);
      check({tag, " overrun"}, 32'(ovr0), 0);
      check({tag, " d1 busy"}, 32'(busy1), 0);
   endtask

   initial begin
      int o0, o1, b0, b1;
      rst_n = 1'b0; x_in = '0; y_in = '0; valid_in = '0; tabulate_in = 1'b0;
      idle(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Frame A: exact centres, out-of-range pixels ignored; tab pixel (5,6) opens frame B.
      feed_frame_a();
      tab_and_wait(2'b01, 47, 47);
      exp_ch(107, 50, 16, 1); exp_ch(300, 207, 16, 1); check_frame(0);
      exp_ch(107, 50, 16, 1); exp_ch(300, 207, 16, 1); check_frame(1);

      // Frame B: ch0 reaches 16 only with the tab pixel; ch1 under the gate on d0.
      for (int i = 0; i < 15; i++) drive(20 + i, 10, 2'b01, 1'b0);
      for (int i = 0; i < 5; i++) drive(400, 400, 2'b10, 1'b0);
      tab_and_wait(2'b00, 26, 47);
      exp_ch(25, 9, 16, 1); exp_ch(300, 207, 5, 0); check_frame(0);
      exp_ch(25, 9, 16, 1); exp_ch(400, 400, 5, 1); check_frame(1);

      // Frame C: floor division on d1; everything gated on d0.
      drive(10, 20, 2'b01, 1'b0);
      drive(11, 20, 2'b01, 1'b0);
      drive(13, 22, 2'b01, 1'b0);
      tab_and_wait(2'b00, 5, 26);
      exp_ch(25, 9, 3, 0); exp_ch(300, 207, 0, 0); check_frame(0);
      exp_ch(11, 20, 3, 1); exp_ch(400, 400, 0, 0); check_frame(1);

      // Overrun: frame D abandoned by a tab 10 cycles later carrying frame E.
      for (int i = 0; i < 16; i++) drive(200, 100, 2'b01, 1'b0);
      for (int i = 0; i < 16; i++) drive(50, 60, 2'b10, 1'b0);
      o0 = ovr0_cnt; o1 = ovr1_cnt; b0 = v0_cnt; b1 = v1_cnt;
      drive(0, 0, 2'b00, 1'b1);
      for (int i = 0; i < 9; i++) drive(10 * i + 3, i + 1, 2'b11, 1'b0);
      drive(0, 0, 2'b00, 1'b1);
      check("d0 busy at overrun", 32'(busy0), 1);
      check("d1 busy at overrun", 32'(busy1), 1);
      idle(60);
      check("d0 overrun pulses", 32'(ovr0_cnt - o0), 1);
      check("d1 overrun pulses", 32'(ovr1_cnt - o1), 1);
      check("d0 valid after overrun", 32'(v0_cnt - b0), 1);
      check("d1 valid after overrun", 32'(v1_cnt - b1), 1);
      check("d0 overrun latency", 32'(lat0), 5);
      check("d1 overrun latency", 32'(lat1), 47);
      exp_ch(25, 9, 9, 0); exp_ch(300, 207, 9, 0); check_frame(0);
      exp_ch(43, 5, 9, 1); exp_ch(43, 5, 9, 1); check_frame(1);

      // Reset in the middle of a division, then a clean frame.
      feed_frame_a();
      drive(0, 0, 2'b00, 1'b1);
      idle(5);
      check("busy before reset", 32'(busy0), 1);
      rst_n = 1'b0;
      idle(2);
      check_all_zero("mid reset");
      rst_n = 1'b1;
      idle(1);
      feed_frame_a();
      tab_and_wait(2'b00, 47, 47);
      exp_ch(107, 50, 16, 1); exp_ch(300, 207, 16, 1); check_frame(0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
